// File: rtl/bp_me_stream_to_burst.sv
`default_nettype none
// ============================================================================
// bp_me_stream_to_burst: stream (header per beat) to burst (header once + data).
// Optional define BP_ME_STREAM_TO_BURST_HDR_CHECK_EN enables sticky hdr_err_o.
// Revision: 1.0
// ============================================================================
module bp_me_stream_to_burst #(
    parameter int          paddr_width_p   = 40,
    parameter int          data_width_p    = 64,
    parameter int          payload_width_p = 16,
    parameter logic [15:0] stream_mask_p   = 16'h0002,
    localparam int         hdr_width_lp    = payload_width_p + 3 + paddr_width_p + 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [hdr_width_lp-1:0] msg_header_i,
    input  logic [data_width_p-1:0] msg_data_i,
    input  logic                    msg_v_i,
    output logic                    msg_ready_and_o,

    output logic [hdr_width_lp-1:0] msg_header_o,
    output logic                    msg_header_v_o,
    input  logic                    msg_header_ready_and_i,

    output logic [data_width_p-1:0] msg_data_o,
    output logic                    msg_data_v_o,
    output logic                    msg_data_last_o,
    input  logic                    msg_data_ready_and_i,

    output logic                    hdr_err_o
);

    // Header layout, LSB first: msg_type[3:0], subop[7:4], addr, size[2:0], payload
    localparam int ADDR_LSB = 8;
    localparam int SIZE_LSB = ADDR_LSB + paddr_width_p;
    localparam int LG_DW    = $clog2(data_width_p);
    localparam int CNT_W    = $clog2(1024 / data_width_p) + 1;

    logic [3:0]       msg_type;
    logic [2:0]       msg_size;
    logic [10:0]      size_bits;
    logic [10:0]      beats_raw;
    logic [CNT_W-1:0] len;
    logic             last_beat;
    logic             hdr_done;
    logic             dat_done;
    logic             accept;

    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             hdr_sent_q, hdr_sent_d;

    assign msg_type  = msg_header_i[3:0];
    assign msg_size  = msg_header_i[SIZE_LSB +: 3];
    assign size_bits = 11'd8 << msg_size;
    assign beats_raw = size_bits >> LG_DW;

    // Messages narrower than one beat still occupy a single beat
    always_comb begin
        len = '0;
        if (stream_mask_p[msg_type]) begin
            len = (beats_raw == 11'd0) ? CNT_W'(1) : CNT_W'(beats_raw);
        end
    end

    assign last_beat       = (cnt_q == len - CNT_W'(1));

    assign msg_header_o    = msg_header_i;
    assign msg_header_v_o  = msg_v_i & ~hdr_sent_q & (cnt_q == '0);
    assign msg_data_o      = msg_data_i;
    assign msg_data_v_o    = msg_v_i & (len != '0);
    assign msg_data_last_o = last_beat;

    assign hdr_done        = hdr_sent_q | (cnt_q != '0) | (msg_header_v_o & msg_header_ready_and_i);
    assign dat_done        = (len == '0) | (msg_data_v_o & msg_data_ready_and_i);
    assign msg_ready_and_o = hdr_done & dat_done;
    assign accept          = msg_v_i & msg_ready_and_o;

    always_comb begin
        cnt_d      = cnt_q;
        hdr_sent_d = hdr_sent_q;
        if (accept) begin
            hdr_sent_d = 1'b0;
            cnt_d      = ((len == '0) || last_beat) ? '0 : cnt_q + CNT_W'(1);
        end else if (msg_header_v_o & msg_header_ready_and_i) begin
            // Header consumed while data stalls: never offer it again for this beat
            hdr_sent_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            hdr_sent_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hdr_sent_q <= hdr_sent_d;
        end
    end

`ifdef BP_ME_STREAM_TO_BURST_HDR_CHECK_EN
    logic [paddr_width_p-1:0] msg_addr;
    logic [paddr_width_p-1:0] wrap_mask;
    logic [paddr_width_p-1:0] beat_off;
    logic [paddr_width_p-1:0] exp_addr;
    logic                     hdr_mismatch;

    logic [3:0]               first_type_q;
    logic [2:0]               first_size_q;
    logic [paddr_width_p-1:0] first_addr_q;
    logic                     hdr_err_q;

    assign msg_addr  = msg_header_i[ADDR_LSB +: paddr_width_p];
    assign wrap_mask = (paddr_width_p'(1) << first_size_q) - paddr_width_p'(1);
    assign beat_off  = paddr_width_p'(cnt_q) << (LG_DW - 3);
    // Successive beats advance by one beat width, wrapping inside the size-aligned block
    assign exp_addr  = (first_addr_q & ~wrap_mask) | ((first_addr_q + beat_off) & wrap_mask);

    assign hdr_mismatch = (msg_type != first_type_q) | (msg_size != first_size_q)
                        | (msg_addr != exp_addr);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            first_type_q <= '0;
            first_size_q <= '0;
            first_addr_q <= '0;
            hdr_err_q    <= 1'b0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                first_type_q <= msg_type;
                first_size_q <= msg_size;
                first_addr_q <= msg_addr;
            end else if (hdr_mismatch) begin
                hdr_err_q <= 1'b1;
            end
        end
    end

    assign hdr_err_o = hdr_err_q;
`else
    assign hdr_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_stream_to_burst.sv
`default_nettype none
// ============================================================================
// tb_bp_me_stream_to_burst: directed self-checking bench, 64-bit beats.
// Revision: 1.0
// ============================================================================
module tb_bp_me_stream_to_burst;

    localparam int PADDR = 40;
    localparam int DW    = 64;
    localparam int PLW   = 16;
    localparam int HDRW  = PLW + 3 + PADDR + 8;
`ifdef BP_ME_STREAM_TO_BURST_HDR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [HDRW-1:0] hdr_i;
    logic [DW-1:0]   data_i;
    logic            msg_v;
    logic            rdy;
    logic [HDRW-1:0] hdr_o;
    logic            hdr_v;
    logic            hdr_rdy;
    logic [DW-1:0]   data_o;
    logic            data_v;
    logic            last;
    logic            dat_rdy;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;
    int hdr_cnt;

    always #5 clk = ~clk;

    bp_me_stream_to_burst #(
        .paddr_width_p  (PADDR),
        .data_width_p   (DW),
        .payload_width_p(PLW),
        .stream_mask_p  (16'h0002)
    ) dut (
        .clk_i                 (clk),
        .reset_n_i             (reset_n),
        .msg_header_i          (hdr_i),
        .msg_data_i            (data_i),
        .msg_v_i               (msg_v),
        .msg_ready_and_o       (rdy),
        .msg_header_o          (hdr_o),
        .msg_header_v_o        (hdr_v),
        .msg_header_ready_and_i(hdr_rdy),
        .msg_data_o            (data_o),
        .msg_data_v_o          (data_v),
        .msg_data_last_o       (last),
        .msg_data_ready_and_i  (dat_rdy),
        .hdr_err_o             (err)
    );

    function automatic logic [HDRW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                               input logic [PADDR-1:0] a);
        mk_hdr = {16'h5A5A, s, a, 4'h0, t};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a beat just after the clock edge, then move to the sampling point
    task automatic drive(input logic [3:0] t, input logic [2:0] s, input logic [PADDR-1:0] a,
                         input logic [DW-1:0] d, input logic hr, input logic dr);
        msg_v   = 1'b1;
        hdr_i   = mk_hdr(t, s, a);
        data_i  = d;
        hdr_rdy = hr;
        dat_rdy = dr;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        msg_v   = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; msg_v = 1'b0; hdr_i = '0; data_i = '0; hdr_rdy = 1'b0; dat_rdy = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_hdr_v", hdr_v, 0);
        chk("rst_data_v", data_v, 0);
        chk("rst_err", err, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_hdr_v", hdr_v, 0);
        chk("idle_data_v", data_v, 0);
        tick();

        // 64B write, all readies high: one header, 8 beats, last on the 8th
        hdr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(4'd1, 3'd6, 40'h1000 + 40'(i * 8), 64'hA000 + 64'(i), 1'b1, 1'b1);
            if (hdr_v) hdr_cnt++;
            if (i == 0) chk("w_hdr_o", hdr_o, mk_hdr(4'd1, 3'd6, 40'h1000));
            chk("w_data_v", data_v, 1);
            chk("w_data_o", data_o, 64'hA000 + 64'(i));
            chk("w_last", last, (i == 7));
            chk("w_ready", rdy, 1);
            tick();
        end
        chk("w_hdr_count", hdr_cnt, 1);
        chk("w_err", err, 0);

        // Header-only read: accepted same cycle, counter stays at zero
        drive(4'd0, 3'd6, 40'h6000, 64'h0, 1'b1, 1'b1);
        chk("r_hdr_v", hdr_v, 1);
        chk("r_data_v", data_v, 0);
        chk("r_ready", rdy, 1);
        tick();
        drive(4'd0, 3'd6, 40'h6040, 64'h0, 1'b0, 1'b1);
        chk("r2_hdr_v", hdr_v, 1);
        chk("r2_ready_hdr_stall", rdy, 0);
        hdr_rdy = 1'b1;
        #1;
        chk("r2_ready", rdy, 1);
        tick();

        // Header ready low 3 cycles: nothing consumed, then normal 8-beat burst
        for (int c = 0; c < 3; c++) begin
            drive(4'd1, 3'd6, 40'h2000, 64'hB000, 1'b0, 1'b1);
            chk("hs_hdr_v", hdr_v, 1);
            chk("hs_data_v", data_v, 1);
            chk("hs_ready", rdy, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(4'd1, 3'd6, 40'h2000 + 40'(i * 8), 64'hB000 + 64'(i), 1'b1, 1'b1);
            chk("hs_beat_hdr_v", hdr_v, (i == 0));
            chk("hs_beat_ready", rdy, 1);
            chk("hs_beat_last", last, (i == 7));
            tick();
        end

        // Data stalled while header taken: header not re-offered
        drive(4'd1, 3'd4, 40'h4000, 64'hC000, 1'b1, 1'b0);
        chk("ds_hdr_v0", hdr_v, 1);
        chk("ds_ready0", rdy, 0);
        tick();
        drive(4'd1, 3'd4, 40'h4000, 64'hC000, 1'b1, 1'b0);
        chk("ds_hdr_v1", hdr_v, 0);
        chk("ds_ready1", rdy, 0);
        tick();
        drive(4'd1, 3'd4, 40'h4000, 64'hC000, 1'b1, 1'b1);
        chk("ds_hdr_v2", hdr_v, 0);
        chk("ds_ready2", rdy, 1);
        chk("ds_last2", last, 0);
        tick();
        drive(4'd1, 3'd4, 40'h4008, 64'hC001, 1'b1, 1'b1);
        chk("ds_hdr_v3", hdr_v, 0);
        chk("ds_last3", last, 1);
        chk("ds_ready3", rdy, 1);
        tick();

        // Single-beat messages back to back, including sub-beat size 1B
        for (int i = 0; i < 4; i++) begin
            drive(4'd1, 3'd3, 40'h5000 + 40'(i * 64), 64'hD000 + 64'(i), 1'b1, 1'b1);
            chk("b2b_hdr_v", hdr_v, 1);
            chk("b2b_last", last, 1);
            chk("b2b_ready", rdy, 1);
            tick();
        end
        drive(4'd1, 3'd0, 40'h5100, 64'hE0, 1'b1, 1'b1);
        chk("sz0_data_v", data_v, 1);
        chk("sz0_last", last, 1);
        chk("sz0_hdr_v", hdr_v, 1);
        tick();

        // Address skew on beat 3 of 8
        for (int i = 0; i < 8; i++) begin
            drive(4'd1, 3'd6, (i == 3) ? 40'h3058 : 40'h3000 + 40'(i * 8), 64'hF000, 1'b1, 1'b1);
            chk("hc_ready", rdy, 1);
            tick();
            if (i == 3) begin
                @(negedge clk);
                chk("hc_err_set", err, EXP_ERR);
            end
        end
        msg_v = 1'b0;
        @(negedge clk);
        chk("hc_err_held", err, EXP_ERR);
        tick();
        pulse_reset();
        chk("hc_err_clr", err, 0);
        tick();

        // Reset mid-message restarts with a fresh header
        for (int i = 0; i < 2; i++) begin
            drive(4'd1, 3'd6, 40'h7000 + 40'(i * 8), 64'h1, 1'b1, 1'b1);
            tick();
        end
        drive(4'd1, 3'd6, 40'h7010, 64'h1, 1'b1, 1'b1);
        chk("mr_hdr_v_mid", hdr_v, 0);
        tick();
        pulse_reset();
        tick();
        drive(4'd1, 3'd6, 40'h8000, 64'h2, 1'b1, 1'b1);
        chk("mr_hdr_v", hdr_v, 1);
        chk("mr_last", last, 0);
        tick();
        msg_v = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
